// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned LAT_W   = 2;
   localparam int unsigned RETRY_W = 3;

   localparam logic [DATA_W-1:0] DEF_EXPECTED_ID = 32'd0;
   localparam logic [DATA_W-1:0] DEF_EXPECTED_TS = 32'd1354258592;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_ID  = 3'd1,
      ST_LAT_ID = 3'd2,
      ST_RD_TS  = 3'd3,
      ST_LAT_TS = 3'd4,
      ST_CHECK  = 3'd5,
      ST_GAP    = 3'd6,
      ST_DONE   = 3'd7
   } state_e;

   // Read completion: strobe plus the slave word to capture on that cycle.
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } rd_rsp_t;

endpackage

// File: rtl/sysid_read_port.sv
// Single-word Avalon-MM read master: request hold, handshake, latency count, capture strobe.
module sysid_read_port
   import sysid_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              issue,
   input  logic              issue_addr,
   output logic              avm_read,
   output logic              avm_address,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic              accept_c,
   output rd_rsp_t           rsp_c
);

   localparam bit ZERO_LAT = (READ_LATENCY == 0);

   logic [LAT_W-1:0] lat_cnt;

   assign accept_c = avm_read & ~avm_waitrequest;

   // Data is valid in the accept cycle, or on the last latency cycle after it.
   assign rsp_c.valid = ZERO_LAT ? accept_c : (lat_cnt == LAT_W'(1));
   assign rsp_c.data  = avm_readdata;

   // Hold the read strobe until accepted; a new issue in the accept cycle keeps it high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
      end else if (issue) begin
         avm_read    <= 1'b1;
         avm_address <= issue_addr;
      end else if (accept_c) begin
         avm_read    <= 1'b0;
      end
   end

   // Count down the read latency after each accepted read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt <= '0;
      end else if (accept_c) begin
         lat_cnt <= LAT_W'(READ_LATENCY);
      end else if (lat_cnt != '0) begin
         lat_cnt <= lat_cnt - LAT_W'(1);
      end
   end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sequencer: reads ID and timestamp words, compares, retries, reports pass/fail.
module sysid_boot_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID  = DEF_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS  = DEF_EXPECTED_TS,
   parameter int unsigned READ_LATENCY = 0,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned RETRY_GAP    = 16,
   parameter bit          AUTO_START   = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [2:0]  retry_count,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   localparam bit                   ZERO_LAT  = (READ_LATENCY == 0);
   localparam int unsigned          GAP_W     = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
   localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(RETRY_GAP - 1);
   localparam logic [RETRY_W-1:0]   RETRY_MAX = RETRY_W'(MAX_RETRIES);

   state_e              state_q;
   state_e              state_d;
   logic                first_q;
   logic                start_q;
   logic                start_eff_c;
   logic                idle_like_c;
   logic [GAP_W-1:0]    gap_cnt_q;
   logic [GAP_W-1:0]    gap_cnt_d;
   logic                id_match_c;
   logic                ts_match_c;
   logic                issue_c;
   logic                issue_addr_c;
   logic                accept_c;
   rd_rsp_t             rsp_c;

   logic                busy_d;
   logic                done_d;
   logic                pass_d;
   logic                fail_d;
   logic                id_ok_d;
   logic                ts_ok_d;
   logic [RETRY_W-1:0]  retry_d;
   logic [DATA_W-1:0]   cap_id_d;
   logic [DATA_W-1:0]   cap_ts_d;

   assign start_eff_c = start | (AUTO_START & first_q);
   assign idle_like_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign id_match_c  = (captured_id == EXPECTED_ID);
   assign ts_match_c  = (captured_ts == EXPECTED_TS);

   // A new read is issued on entry to either read state.
   assign issue_c      = ((state_d == ST_RD_ID) && (state_q != ST_RD_ID)) ||
                         ((state_d == ST_RD_TS) && (state_q != ST_RD_TS));
   assign issue_addr_c = (state_d == ST_RD_TS) ? ADDR_TS : ADDR_ID;

   sysid_read_port #(
      .READ_LATENCY (READ_LATENCY)
   ) u_read_port (
      .clock           (clock),
      .reset_n         (reset_n),
      .issue           (issue_c),
      .issue_addr      (issue_addr_c),
      .avm_read        (avm_read),
      .avm_address     (avm_address),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .accept_c        (accept_c),
      .rsp_c           (rsp_c)
   );

   // Register the start request; only honoured when idle or done, never queued.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         first_q <= 1'b1;
         start_q <= 1'b0;
      end else begin
         first_q <= 1'b0;
         start_q <= start_eff_c & idle_like_c & ~start_q;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_q) state_d = ST_RD_ID;
         end
         ST_RD_ID: begin
            if (accept_c) state_d = ZERO_LAT ? ST_RD_TS : ST_LAT_ID;
         end
         ST_LAT_ID: begin
            if (rsp_c.valid) state_d = ST_RD_TS;
         end
         ST_RD_TS: begin
            if (accept_c) state_d = ZERO_LAT ? ST_CHECK : ST_LAT_TS;
         end
         ST_LAT_TS: begin
            if (rsp_c.valid) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (id_match_c && ts_match_c) state_d = ST_DONE;
            else if (retry_count < RETRY_MAX) state_d = ST_GAP;
            else state_d = ST_DONE;
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = ST_RD_ID;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs and counters.
   always_comb begin
      busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d    = done;
      pass_d    = pass;
      fail_d    = fail;
      id_ok_d   = id_ok;
      ts_ok_d   = ts_ok;
      retry_d   = retry_count;
      cap_id_d  = captured_id;
      cap_ts_d  = captured_ts;
      gap_cnt_d = '0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_q) begin
               done_d  = 1'b0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
               id_ok_d = 1'b0;
               ts_ok_d = 1'b0;
               retry_d = '0;
            end
         end
         ST_RD_ID, ST_LAT_ID: begin
            if (rsp_c.valid) cap_id_d = rsp_c.data;
         end
         ST_RD_TS, ST_LAT_TS: begin
            if (rsp_c.valid) cap_ts_d = rsp_c.data;
         end
         ST_CHECK: begin
            id_ok_d = id_match_c;
            ts_ok_d = ts_match_c;
            if (id_match_c && ts_match_c) begin
               done_d = 1'b1;
               pass_d = 1'b1;
            end else if (retry_count < RETRY_MAX) begin
               retry_d = retry_count + RETRY_W'(1);
            end else begin
               done_d = 1'b1;
               fail_d = 1'b1;
            end
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
         end
         default: ;
      endcase
   end

   // Output and counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         retry_count <= '0;
         captured_id <= '0;
         captured_ts <= '0;
         gap_cnt_q   <= '0;
      end else begin
         busy        <= busy_d;
         done        <= done_d;
         pass        <= pass_d;
         fail        <= fail_d;
         id_ok       <= id_ok_d;
         ts_ok       <= ts_ok_d;
         retry_count <= retry_d;
         captured_id <= cap_id_d;
         captured_ts <= cap_ts_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: zero-latency checker (A) and two-cycle-latency, no-autostart checker (B).
module tb_sysid_boot_checker;

   localparam logic [31:0] GOOD_TS = 32'd1354258592;
   localparam logic [31:0] BAD_TS  = 32'h1234_5678;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // DUT A signals
   logic        rst_a_n, start_a, read_a, addr_a, wr_a;
   logic [31:0] rdata_a;
   logic        busy_a, done_a, pass_a, fail_a, id_ok_a, ts_ok_a;
   logic [2:0]  retry_a;
   logic [31:0] cap_id_a, cap_ts_a;

   // DUT B signals
   logic        rst_b_n, start_b, read_b, addr_b, wr_b;
   logic [31:0] rdata_b;
   logic        busy_b, done_b, pass_b, fail_b, id_ok_b, ts_ok_b;
   logic [2:0]  retry_b;
   logic [31:0] cap_id_b, cap_ts_b;

   int total = 0;
   int bad   = 0;

   // Slave A: 0 = good words, 1 = bad timestamp, 2 = bad timestamp on first pair only.
   int ts_mode_a   = 0;
   int pair_cnt_a  = 0;
   int pair_base_a = 0;

   always_comb begin
      rdata_a = 32'h0;
      if (addr_a) begin
         if (ts_mode_a == 1 || (ts_mode_a == 2 && pair_cnt_a == pair_base_a)) rdata_a = BAD_TS;
         else rdata_a = GOOD_TS;
      end
   end

   always @(posedge clock) begin
      if (read_a && addr_a && !wr_a) pair_cnt_a <= pair_cnt_a + 1;
   end

   // Slave B: garbage in 1st post-accept cycle, real word in the 2nd.
   logic acc1_b, acc2_b, a1_b, a2_b;
   always @(posedge clock or negedge rst_b_n) begin
      if (!rst_b_n) begin
         acc1_b <= 1'b0; acc2_b <= 1'b0; a1_b <= 1'b0; a2_b <= 1'b0;
      end else begin
         acc1_b <= read_b & ~wr_b;
         a1_b   <= addr_b;
         acc2_b <= acc1_b;
         a2_b   <= a1_b;
      end
   end

   always_comb begin
      rdata_b = 32'hFFFF_FFFF;
      if (acc2_b) rdata_b = a2_b ? GOOD_TS : 32'h0;
      else if (acc1_b) rdata_b = 32'hDEAD_BEEF;
   end

   sysid_boot_checker #(
      .READ_LATENCY (0),
      .MAX_RETRIES  (3),
      .RETRY_GAP    (16),
      .AUTO_START   (1'b1)
   ) dut_a (
      .clock           (clock),
      .reset_n         (rst_a_n),
      .start           (start_a),
      .avm_address     (addr_a),
      .avm_read        (read_a),
      .avm_waitrequest (wr_a),
      .avm_readdata    (rdata_a),
      .busy            (busy_a),
      .done            (done_a),
      .pass            (pass_a),
      .fail            (fail_a),
      .id_ok           (id_ok_a),
      .ts_ok           (ts_ok_a),
      .retry_count     (retry_a),
      .captured_id     (cap_id_a),
      .captured_ts     (cap_ts_a)
   );

   sysid_boot_checker #(
      .READ_LATENCY (2),
      .MAX_RETRIES  (3),
      .RETRY_GAP    (4),
      .AUTO_START   (1'b0)
   ) dut_b (
      .clock           (clock),
      .reset_n         (rst_b_n),
      .start           (start_b),
      .avm_address     (addr_b),
      .avm_read        (read_b),
      .avm_waitrequest (wr_b),
      .avm_readdata    (rdata_b),
      .busy            (busy_b),
      .done            (done_b),
      .pass            (pass_b),
      .fail            (fail_b),
      .id_ok           (id_ok_b),
      .ts_ok           (ts_ok_b),
      .retry_count     (retry_b),
      .captured_id     (cap_id_b),
      .captured_ts     (cap_ts_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Pulse start for one sampled edge; returns #1 after that edge.
   task automatic pulse_start(input bit sel_b);
      @(negedge clock);
      if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Edges after the start edge until done is seen, bounded by max.
   task automatic wait_done(input bit sel_b, input int max, output int n);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!(sel_b ? done_b : done_a) && n < max);
   endtask

   initial begin
      int   n;
      logic stable;

      rst_a_n = 1'b0; rst_b_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      wr_a    = 1'b0; wr_b    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("a reset flags", 32'({busy_a, done_a, pass_a, fail_a, id_ok_a, ts_ok_a, read_a, addr_a, retry_a}), 32'h0);
      chk("a reset cap_id", cap_id_a, 32'h0);
      chk("a reset cap_ts", cap_ts_a, 32'h0);

      // Auto-start pass, done on the 5th edge after release.
      @(negedge clock) rst_a_n = 1'b1;
      @(posedge clock); #1;
      chk("t1 e1 read", 32'(read_a), 32'd0);
      @(posedge clock); #1;
      chk("t1 e2 read/addr", 32'({read_a, addr_a}), 32'b10);
      @(posedge clock); #1;
      chk("t1 e3 read/addr", 32'({read_a, addr_a}), 32'b11);
      @(posedge clock); #1;
      chk("t1 e4 done/busy", 32'({done_a, busy_a}), 32'b01);
      @(posedge clock); #1;
      chk("t1 e5 done/pass/fail", 32'({done_a, pass_a, fail_a}), 32'b110);
      chk("t1 retry", 32'(retry_a), 32'd0);
      chk("t1 cap_ts", cap_ts_a, GOOD_TS);
      chk("t1 read idle", 32'({busy_a, read_a}), 32'b00);

      // Bad timestamp: 4 read pairs, then fail.
      ts_mode_a = 1;
      pair_base_a = pair_cnt_a;
      pulse_start(1'b0);
      wait_done(1'b0, 200, n);
      chk("t2 cycles", 32'(n), 32'd61);
      chk("t2 pass/fail", 32'({pass_a, fail_a}), 32'b01);
      chk("t2 retry", 32'(retry_a), 32'd3);
      chk("t2 id_ok/ts_ok", 32'({id_ok_a, ts_ok_a}), 32'b10);
      chk("t2 pairs", 32'(pair_cnt_a - pair_base_a), 32'd4);
      chk("t2 cap_ts", cap_ts_a, BAD_TS);

      // Five-cycle stall on the timestamp read.
      ts_mode_a = 0;
      pulse_start(1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      n = 2;
      chk("t3 ts read issued", 32'({read_a, addr_a}), 32'b11);
      wr_a = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         n++;
         if (!(read_a && addr_a)) stable = 1'b0;
      end
      wr_a = 1'b0;
      while (!done_a && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("t3 stable", 32'(stable), 32'd1);
      chk("t3 cycles", 32'(n), 32'd9);
      chk("t3 pass", 32'({pass_a, fail_a}), 32'b10);

      // First attempt bad, retry passes; start during GAP is ignored.
      ts_mode_a = 2;
      pair_base_a = pair_cnt_a;
      pulse_start(1'b0);
      n = 0;
      stable = 1'b0;
      do begin
         @(posedge clock); #1;
         n++;
         start_a = (n == 6);
         if (n == 10) stable = busy_a;
      end while (!done_a && n < 200);
      start_a = 1'b0;
      chk("t5 busy in gap", 32'(stable), 32'd1);
      chk("t5 cycles", 32'(n), 32'd23);
      chk("t5 pass/retry", 32'({pass_a, fail_a, retry_a}), 32'b10_001);
      chk("t5 pairs", 32'(pair_cnt_a - pair_base_a), 32'd2);
      repeat (10) @(posedge clock);
      #1;
      chk("t5 no rerun", 32'({done_a, busy_a}), 32'b10);
      chk("t5 pairs after", 32'(pair_cnt_a - pair_base_a), 32'd2);

      // Latency 2: no auto start, garbage ignored, pass.
      chk("b reset cap", cap_ts_b, 32'h0);
      @(negedge clock) rst_b_n = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      chk("b no autostart", 32'({busy_b, done_b, read_b}), 32'b000);
      pulse_start(1'b1);
      wait_done(1'b1, 100, n);
      chk("t4 cycles", 32'(n), 32'd8);
      chk("t4 pass/retry", 32'({pass_b, fail_b, retry_b}), 32'b10_000);
      chk("t4 cap_id", cap_id_b, 32'h0);
      chk("t4 cap_ts", cap_ts_b, GOOD_TS);

      // Reset during LAT_TS, then a fresh start passes.
      pulse_start(1'b1);
      repeat (5) begin
         @(posedge clock); #1;
      end
      chk("t6 in lat_ts", 32'({busy_b, read_b, addr_b}), 32'b101);
      rst_b_n = 1'b0;
      #1;
      chk("t6 reset flags", 32'({busy_b, done_b, pass_b, fail_b, id_ok_b, ts_ok_b, read_b, addr_b, retry_b}), 32'h0);
      chk("t6 reset cap_ts", cap_ts_b, 32'h0);
      @(negedge clock) rst_b_n = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      chk("t6 idle", 32'({busy_b, done_b, read_b}), 32'b000);
      pulse_start(1'b1);
      wait_done(1'b1, 100, n);
      chk("t6 cycles", 32'(n), 32'd8);
      chk("t6 pass", 32'({pass_b, fail_b, id_ok_b, ts_ok_b}), 32'b1011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Boot-time sequencer for the system-ID control slave. After reset, or on request, it acts as a single Avalon-MM read master: it reads the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values. On mismatch it retries after a fixed gap, and finally reports pass/fail. It sits between the SOPC interconnect and the board reset/status logic, so the host CPU is held until the hardware image is confirmed.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, required word at address 0
- EXPECTED_TS, 32'd1354258592, required word at address 1
- READ_LATENCY, 0, cycles from accepted read to valid readdata; legal range 0..3
- MAX_RETRIES, 3, extra attempts after the first failure; legal range 0..7
- RETRY_GAP, 16, idle cycles between attempts; must be ≥1
- AUTO_START, 1, start one check automatically after reset release

Ports:
- clock  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a check; honoured only in IDLE or DONE
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read strobe; held until waitrequest is low
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  level; result is valid
- pass  out  1  both words matched (valid while done)
- fail  out  1  retries exhausted without a match (valid while done)
- id_ok, ts_ok  out  1 each  per-word match result from the last attempt
- retry_count  out  3  number of retries used so far
- captured_id, captured_ts  out  32 each  last values read

## Operation
- Reset values: all outputs 0, state IDLE, retry_count 0, captured words 0.
- If AUTO_START=1, the first cycle after reset release behaves as if start were high.
- FSM states: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, GAP, DONE.
- IDLE/DONE + start → RD_ID. This transition clears done, pass, fail, id_ok, ts_ok and retry_count.
- RD_ID: avm_read=1, avm_address=0.
  - Read accepted when waitrequest=0.
  - If READ_LATENCY=0, capture readdata in the accept cycle and go to RD_TS.
  - Otherwise go to LAT_ID, count READ_LATENCY cycles, capture on the last cycle, then go to RD_TS.
- RD_TS/LAT_TS: same sequence with avm_address=1, capturing into captured_ts, then go to CHECK.
- CHECK: one cycle. Register id_ok and ts_ok.
  - Both ok → DONE with pass=1.
  - Otherwise, retry_count<MAX_RETRIES → increment retry_count, go to GAP.
  - Otherwise → DONE with fail=1.
- GAP: count RETRY_GAP cycles, then go to RD_ID.
- busy=1 in every state except IDLE and DONE. pass and fail are never both 1.
- start while busy is ignored; it is not queued.
- Outside RD_ID and RD_TS, avm_read=0 and avm_address holds its last value.
- Reset asserted mid-operation aborts immediately to the reset values. An in-flight read is dropped.

## Timing
- All state and outputs are registered. The only combinational dependencies on inputs are the waitrequest/readdata sampling points.
- With waitrequest=0 and READ_LATENCY=0, start sampled at edge k gives:
  - avm_read=1 with address 0 in cycle k+1
  - avm_read=1 with address 1 in cycle k+2
  - CHECK in cycle k+3
  - done=1 from edge k+4
- Each waitrequest=1 cycle adds one cycle. Each latency cycle adds one cycle per read.
- A failed attempt costs 3 + 2·READ_LATENCY + RETRY_GAP cycles before the next RD_ID.
- Worst-case fail time with no stalls: (MAX_RETRIES+1)·(3+2·READ_LATENCY) + MAX_RETRIES·RETRY_GAP + 1 cycles.

## Structure
- Shared package sysid_pkg holds:
  - the state enum
  - default EXPECTED_ID/EXPECTED_TS constants
  - the address constants ADDR_ID=0 and ADDR_TS=1
- One sub-module, sysid_read_port, is natural. It owns the request hold, waitrequest handshake, latency counter and capture strobe, and is instantiated once and reused for both words.

## Test plan
- Combinational model slave returning 0 / 1354258592, latency 0, AUTO_START=1 → done=1, pass=1, retry_count=0; done rises 4 cycles after the first post-reset edge.
- Slave returns timestamp 0x12345678, MAX_RETRIES=3, RETRY_GAP=16 → exactly 4 read pairs are issued, then fail=1, retry_count=3, ts_ok=0, id_ok=1.
- waitrequest held high 5 cycles on the address-1 read → avm_read and address=1 are stable throughout, and done is delayed by exactly 5 cycles.
- READ_LATENCY=2, slave data valid only in the 2nd post-accept cycle → correct capture and pass=1. A corrupted value in cycle 1 is ignored.
- Slave mismatched for the first attempt and correct afterwards → pass=1, retry_count=1; start pulsed during GAP has no effect.
- reset_n dropped during LAT_TS, then released with AUTO_START=0 → all outputs 0, state IDLE; a later start pulse runs a full check to pass.
